min_averager: RTL



---
 rtl/min_averager.sv | 118 +++++++++++
 1 files changed

// File: rtl/min_averager.sv
// Averages windows of 2^LOG2N samples arriving over an active-low dav_/rfd
// handshake and presents each truncated mean over the same handshake downstream.
module min_averager #(
  parameter int LOG2N = 2
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic             dav_in_,
  input  logic [7:0]       x,
  output logic             rfd_in,
  output logic             dav_out_,
  input  logic             rfd_out,
  output logic [7:0]       avg,
  output logic [2:0]       state,
  output logic [LOG2N:0]   cnt
);

  // Handshake: a producer lowers dav_ with data stable; the consumer captures
  // it and drops rfd; the producer then raises dav_, and the consumer raises rfd
  // again once it can take more. Data is only consumed while dav_=0 and rfd=1.
  typedef enum logic [2:0] {
    IN_WAIT  = 3'd0,
    IN_ACK   = 3'd1,
    OUT_WAIT = 3'd2,
    OUT_ACK  = 3'd3,
    OUT_DONE = 3'd4
  } state_t;

  localparam int SW = 8 + LOG2N;
  localparam logic [LOG2N:0] N_CNT   = {1'b1, {LOG2N{1'b0}}};
  localparam logic [LOG2N:0] CNT_ONE = {{LOG2N{1'b0}}, 1'b1};

  state_t          state_q, state_nxt;
  logic [SW-1:0]   sum, sum_nxt;
  logic [LOG2N:0]  cnt_nxt;
  logic            rfd_nxt, dav_nxt;
  logic [7:0]      avg_nxt;

  assign state = state_q;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q  <= IN_WAIT;
      sum      <= '0;
      cnt      <= '0;
      rfd_in   <= 1'b1;
      dav_out_ <= 1'b1;
      avg      <= '0;
    end else begin
      state_q  <= state_nxt;
      sum      <= sum_nxt;
      cnt      <= cnt_nxt;
      rfd_in   <= rfd_nxt;
      dav_out_ <= dav_nxt;
      avg      <= avg_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    sum_nxt   = sum;
    cnt_nxt   = cnt;
    rfd_nxt   = rfd_in;
    dav_nxt   = dav_out_;
    avg_nxt   = avg;
    case (state_q)
      IN_WAIT: begin
        if (!dav_in_) begin
          sum_nxt   = sum + {{LOG2N{1'b0}}, x};
          cnt_nxt   = cnt + CNT_ONE;
          rfd_nxt   = 1'b0;
          state_nxt = IN_ACK;
        end
      end
      IN_ACK: begin
        if (dav_in_) begin
          if (cnt == N_CNT) begin
            state_nxt = OUT_WAIT;
          end else begin
            rfd_nxt   = 1'b1;
            state_nxt = IN_WAIT;
          end
        end
      end
      OUT_WAIT: begin
        if (rfd_out) begin
          avg_nxt   = sum[LOG2N+7:LOG2N];
          dav_nxt   = 1'b0;
          state_nxt = OUT_ACK;
        end
      end
      OUT_ACK: begin
        if (!rfd_out) begin
          dav_nxt   = 1'b1;
          sum_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = OUT_DONE;
        end
      end
      OUT_DONE: begin
        if (rfd_out) begin
          rfd_nxt   = 1'b1;
          state_nxt = IN_WAIT;
        end
      end
      default: begin
        // Unreachable encodings recover to the reset picture.
        state_nxt = IN_WAIT;
        sum_nxt   = '0;
        cnt_nxt   = '0;
        rfd_nxt   = 1'b1;
        dav_nxt   = 1'b1;
        avg_nxt   = '0;
      end
    endcase
  end

endmodule
